// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Memory-side responder for the single-cycle core's data port. Serves a
//   word-addressed RAM (addr[31]==0) and a small MMIO page (addr[31]==1):
//     +0 CONSOLE_DATA  write pushes write_data[7:0] into the TX FIFO, reads 0
//     +4 STATUS        {count, 5'b0, overflow, full, empty}; write bit2 clears overflow
//     +8 CYCLE         free-running cycle counter (only with DMEM_CYCLE_COUNTER_EN)
//   Loads are combinational from addr; stores commit at posedge clk.
//   Console bytes leave on a valid/ready stream (tx_valid/tx_data/tx_ready).
// Ports
//   clk, rst           clock; synchronous active-high reset
//   addr               byte address (addr[1:0] ignored)
//   write_data         store data
//   write_enable       store strobe
//   read_data          load data
//   tx_valid, tx_data  console byte at FIFO head
//   tx_ready           sink accepts the head byte
// Configuration
//   DMEM_CYCLE_COUNTER_EN  defined: CYCLE counter present; undefined: CYCLE reads 0.
module data_memory_responder #(
  parameter int unsigned RamWords     = 256,
  parameter int unsigned ConsoleDepth = 8,
  parameter logic [31:0] MmioBase     = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic [31:0] read_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int RAW = $clog2(RamWords);
  localparam int PW  = $clog2(ConsoleDepth);
  localparam int CW  = PW + 1;

  // ---------------- decode ----------------
  logic            is_mmio;
  logic [31:0]     mmio_off;
  logic            sel_console, sel_status, sel_cycle;
  logic [RAW-1:0]  ram_idx;

  assign is_mmio     = addr[31];
  assign mmio_off    = addr - MmioBase;
  assign sel_console = is_mmio && (mmio_off[31:2] == 30'd0);
  assign sel_status  = is_mmio && (mmio_off[31:2] == 30'd1);
  assign sel_cycle   = is_mmio && (mmio_off[31:2] == 30'd2);
  assign ram_idx     = addr[2 +: RAW];

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{addr[1:0], mmio_off[1:0]};

  // ---------------- RAM (not reset) ----------------
  logic [31:0] ram [RamWords];

  always_ff @(posedge clk) begin
    if (write_enable && !is_mmio) ram[ram_idx] <= write_data;
  end

  // ---------------- console FIFO ----------------
  logic [7:0]    fifo [ConsoleDepth];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          full, empty, push_req, push, pop, ovf_set, ovf_clr;

  assign full     = (count == CW'(ConsoleDepth));
  assign empty    = (count == '0);
  assign pop      = tx_valid && tx_ready;
  assign push_req = write_enable && sel_console;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = write_enable && sel_status && write_data[2];

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Head is driven from state only; forced to 0 when empty so reset shows 0
  // even though the FIFO storage itself is not cleared.
  assign tx_valid = !empty;
  assign tx_data  = empty ? 8'h00 : fifo[rd_ptr];

  // ---------------- cycle counter ----------------
  logic [31:0] cycle_val;
`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;
  always_ff @(posedge clk) begin
    if (rst)                              cycle_cnt <= '0;
    else if (write_enable && sel_cycle)   cycle_cnt <= write_data;
    else                                  cycle_cnt <= cycle_cnt + 32'd1;
  end
  assign cycle_val = cycle_cnt;
`else
  assign cycle_val = '0;
`endif

  // ---------------- read mux ----------------
  logic [31:0] status_word;
  assign status_word = {{(24-CW){1'b0}}, count, 5'b0, overflow, full, empty};

  always_comb begin
    read_data = '0;
    if (!is_mmio)        read_data = ram[ram_idx];
    else if (sel_status) read_data = status_word;
    else if (sel_cycle)  read_data = cycle_val;
  end
endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        write_enable;
  logic [31:0] read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A_CON = 32'h8000_0000;
  localparam logic [31:0] A_STS = 32'h8000_0004;
  localparam logic [31:0] A_CYC = 32'h8000_0008;

  data_memory_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .write_enable(write_enable), .read_data(read_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a);
    addr = a; write_enable = 1'b0; #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; write_data = d; write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; write_data = '0; write_enable = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'd0);
    rd(A_STS);            chk("rst_status", read_data, 32'h0000_0001);
    rd(A_CON);            chk("con_read0", read_data, 32'h0);
    rd(32'h8000_000C);    chk("unmapped_read0", read_data, 32'h0);

    // RAM, same-cycle read-during-write, aliasing
    wr(32'h0000_0010, 32'h1111_1111);
    addr = 32'h0000_0010; write_data = 32'hDEAD_BEEF; write_enable = 1'b1; #1;
    chk("ram_rdw_old", read_data, 32'h1111_1111);
    tick();
    rd(32'h0000_0010);    chk("ram_new", read_data, 32'hDEAD_BEEF);
    rd(32'h0000_0410);    chk("ram_alias", read_data, 32'hDEAD_BEEF);
    rd(32'h0000_0013);    chk("ram_lsb_ignored", read_data, 32'hDEAD_BEEF);

    // write to unmapped MMIO offset: ignored, no push
    wr(32'h8000_0010, 32'h0000_0077);
    chk("unmapped_no_push", {31'b0, tx_valid}, 32'd0);

    // console push x3 then drain
    wr(A_CON, 32'h41); wr(A_CON, 32'h42); wr(A_CON, 32'h43);
    rd(A_STS);            chk("status_3", read_data, 32'h0000_0300);
    chk("head_41_held", {24'b0, tx_data}, 32'h41);
    tx_ready = 1'b1; #1;
    chk("drain_41", {24'b0, tx_data}, 32'h41);
    tick();               chk("drain_42", {24'b0, tx_data}, 32'h42);
    tick();               chk("drain_43", {24'b0, tx_data}, 32'h43);
    tick();               chk("drain_empty", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // overflow: push 9 into depth 8
    for (int i = 0; i < 9; i++) wr(A_CON, 32'h10 + i);
    rd(A_STS);            chk("status_ovf", read_data, 32'h0000_0806);
    wr(A_STS, 32'h0000_0004);
    rd(A_STS);            chk("status_ovf_clr", read_data, 32'h0000_0802);

    // full + simultaneous push/pop
    addr = A_CON; write_data = 32'h5A; write_enable = 1'b1; tx_ready = 1'b1; #1;
    chk("full_pushpop_head", {24'b0, tx_data}, 32'h10);
    tick();
    write_enable = 1'b0; tx_ready = 1'b0;
    rd(A_STS);            chk("full_pushpop_status", read_data, 32'h0000_0802);
    tx_ready = 1'b1; #1;
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("drain_%0d", i), {24'b0, tx_data}, 32'h11 + i);
      tick();
    end
    chk("drain_5a_last", {24'b0, tx_data}, 32'h5A);
    tick();
    chk("drain2_empty", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // cycle counter
`ifdef DMEM_CYCLE_COUNTER_EN
    wr(A_CYC, 32'hFFFF_FFFE);
    rd(A_CYC);            chk("cyc_load", read_data, 32'hFFFF_FFFE);
    tick();               chk("cyc_inc", read_data, 32'hFFFF_FFFF);
    tick();               chk("cyc_wrap", read_data, 32'h0000_0000);
`else
    wr(A_CYC, 32'hFFFF_FFFE);
    rd(A_CYC);            chk("cyc_absent", read_data, 32'h0);
    tick();               chk("cyc_absent2", read_data, 32'h0);
`endif

    // reset mid-operation
    for (int i = 0; i < 5; i++) wr(A_CON, 32'h60 + i);
`ifdef DMEM_CYCLE_COUNTER_EN
    wr(A_CYC, 32'h0000_1234);
    rd(A_CYC);            chk("cyc_pre_rst", read_data, 32'h0000_1234);
`endif
    wr(32'h0000_0020, 32'hCAFE_F00D);
    rd(A_STS);            chk("status_5", read_data, 32'h0000_0500);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    rd(A_STS);            chk("mid_rst_status", read_data, 32'h0000_0001);
    rd(A_CYC);            chk("mid_rst_cycle", read_data, 32'h0);
    rst = 1'b0;
    rd(32'h0000_0020);    chk("ram_survives_rst", read_data, 32'hCAFE_F00D);
    chk("mid_rst_tx_data", {24'b0, tx_data}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
